rrc_brdist: RTL
===============

RRC_BRDIST -- requirements
Module: rrc_brdist

Interface
REQ-001 SHALL have parameter BRC, default 128: number of boot records streamed per run (min 2).
REQ-002 SHALL have parameter BRCW, default $clog2(BRC): record index width.
REQ-003 SHALL have parameter BRDW, default 256: record data width.
REQ-004 SHALL have parameter NPH, default 4: number of delivery phases (min 1).
REQ-005 SHALL have parameter GAPW, default 4: width of the inter-record gap counter.
REQ-006 SHALL have port clksys, input, 1: the single clock.
REQ-007 SHALL have port sysreset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins a run.
REQ-009 SHALL have port gapcyc, input, GAPW: idle cycles inserted after each delivered record.
REQ-010 SHALL have port phend, input, NPH*BRCW: last record index of each phase, phase k in bits [k*BRCW +: BRCW].
REQ-011 SHALL have port brready, input, NPH: per-phase consumer ready.
REQ-012 SHALL have ports rden (output, 1), rdaddr (output, BRCW) and rddat (input, BRDW): record store read port; rddat is valid one cycle after rden.
REQ-013 SHALL have outputs brvld (1), bridx (BRCW), brdat (BRDW), brphase ($clog2(NPH), min 1), busy (1), brdone (1) and brerr (1).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, FETCH, LOAD, SEND, GAP and DONE.
REQ-015 IDLE: start -> WAIT, with bridx=0, brphase=0, brerr=0 and brdone=0.
REQ-016 WAIT: brready[brphase]=1 -> FETCH; otherwise hold indefinitely.
REQ-017 FETCH: rden=1 and rdaddr=bridx for exactly one cycle -> LOAD.
REQ-018 LOAD: brdat<=rddat -> SEND; brdat holds its value in every other state.
REQ-019 SEND: brvld=1 for exactly one cycle; exit to DONE if bridx==BRC-1, otherwise to GAP if gapcyc!=0, otherwise to WAIT.
REQ-020 On SEND exit (not to DONE): bridx+1; if bridx==phend[brphase] and brphase<NPH-1, then brphase+1.
REQ-021 GAP: count gapcyc cycles, then -> WAIT; gapcyc is sampled on SEND exit.
REQ-022 DONE: brdone=1 (sticky); a start pulse -> WAIT, beginning a new run.
REQ-023 brready SHALL be sampled only in WAIT; deasserting it after FETCH SHALL NOT abort the record in flight.
REQ-024 start in WAIT, FETCH, LOAD, SEND or GAP SHALL be ignored.
REQ-025 busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 Minimum record period SHALL be 4+gapcyc cycles (WAIT..SEND plus GAP).
REQ-027 phend entries SHALL be non-decreasing; an entry beyond BRC-1 SHALL have no effect; the final phase SHALL run to BRC-1.

Reset
REQ-028 sysreset=1 SHALL force, on the next edge and from any state including mid-record: state=IDLE, bridx=0, brphase=0, brdat=0, brvld=0, rden=0, rdaddr=0, busy=0, brdone=0, brerr=0, gap counter=0.

Configuration
REQ-029 With macro BRDIST_CHK_EN defined: XOR-accumulate brdat of records 0..BRC-2; on SEND of record BRC-1, set brerr=1 (sticky until next start or reset) if the accumulator differs from that record.
REQ-030 Without BRDIST_CHK_EN: brerr SHALL be tied 0, the port SHALL remain present and no accumulator SHALL exist.

Structure
REQ-031 The brdist_state_e state enum and the default BRC/BRDW/NPH constants SHALL live in a shared package, rrc_pkg.
REQ-032 The checksum SHALL be one sub-module, rrc_brdist_chk, instantiated only under BRDIST_CHK_EN.

Verification (BRC=8, NPH=2, phend={7,3}, brready=2'b11 unless noted)
REQ-033 start, gapcyc=0 -> 8 brvld pulses exactly 4 cycles apart; bridx 0..7; brdat==store[idx]; brphase 0 for idx 0..3, 1 for idx 4..7; brdone=1 after idx 7.
REQ-034 brready=2'b01 -> idx 0..3 delivered, then stall in WAIT with busy=1; raise brready[1] 20 cycles later -> idx 4 delivered 4 cycles later.
REQ-035 gapcyc=3 -> brvld pulses 7 cycles apart; a start pulse mid-run is ignored (bridx sequence unchanged).
REQ-036 sysreset asserted in LOAD of idx 5 -> next cycle all outputs at reset values; a following start restarts from idx 0.
REQ-037 BRDIST_CHK_EN, store[7]=XOR(store[0..6]) -> brerr=0; flip one bit of store[7] -> brerr=1 together with brdone.
REQ-038 In DONE, a start pulse -> brdone clears and a second full run completes identically to REQ-033.

Source files
------------

// File: rtl/rrc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rrc_pkg                                                   |
// | Purpose  : Shared types and default constants for the boot-record    |
// |            distributor (rrc_brdist) and its checksum helper.         |
// | Contents : brdist_state_e  - distributor FSM state encoding          |
// |            c_BRC_DEF       - default records per run                 |
// |            c_BRDW_DEF      - default record data width               |
// |            c_NPH_DEF       - default number of delivery phases       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package rrc_pkg;

  localparam int c_BRC_DEF  = 128;
  localparam int c_BRDW_DEF = 256;
  localparam int c_NPH_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } brdist_state_e;

endpackage
`default_nettype wire

// File: rtl/rrc_brdist_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rrc_brdist_chk                                            |
// | Purpose  : XOR checksum over the delivered records of one run. The   |
// |            final record must equal the XOR of all earlier records;   |
// |            a mismatch raises a sticky error flag.                    |
// | Ports    : clk    - clock                                            |
// |            rst    - synchronous active-high reset                    |
// |            i_clr  - accepted start: clear accumulator and error      |
// |            i_acc  - fold i_dat into the accumulator                  |
// |            i_last - compare i_dat against the accumulator            |
// |            i_dat  - record data being delivered                      |
// |            o_err  - sticky checksum error                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rrc_brdist_chk #(
  parameter int BRDW = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_acc,
  input  logic            i_last,
  input  logic [BRDW-1:0] i_dat,
  output logic            o_err
);

  logic [BRDW-1:0] r_acc;
  logic            r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_acc) begin
        r_acc <= r_acc ^ i_dat;
      end
      if (i_last && (r_acc != i_dat)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/rrc_brdist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rrc_brdist                                                |
// | Purpose  : Streams BRC boot records from a record store to phased    |
// |            consumers. Each record is fetched, loaded and presented   |
// |            for one cycle on brvld, followed by an optional gap.      |
// |            Records advance through NPH phases as bridx passes each   |
// |            phase's last index (phend).                               |
// | Ports    : clksys   - clock                                          |
// |            sysreset - synchronous active-high reset                  |
// |            start    - pulse, begins a run from IDLE or DONE          |
// |            gapcyc   - idle cycles after each delivered record        |
// |            phend    - last record index per phase (BRCW each)        |
// |            brready  - per-phase consumer ready                       |
// |            rden/rdaddr/rddat - store read port, 1-cycle latency      |
// |            brvld/bridx/brdat/brphase - delivered record              |
// |            busy     - run in progress                                |
// |            brdone   - run complete (held until next start)           |
// |            brerr    - checksum error (sticky)                        |
// | Config   : BRDIST_CHK_EN - enables the XOR checksum on brerr;        |
// |            when undefined brerr is constant 0.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rrc_brdist #(
  parameter  int BRC  = rrc_pkg::c_BRC_DEF,
  parameter  int BRCW = $clog2(BRC),
  parameter  int BRDW = rrc_pkg::c_BRDW_DEF,
  parameter  int NPH  = rrc_pkg::c_NPH_DEF,
  parameter  int GAPW = 4,
  localparam int PHW  = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic                clksys,
  input  logic                sysreset,
  input  logic                start,
  input  logic [GAPW-1:0]     gapcyc,
  input  logic [NPH*BRCW-1:0] phend,
  input  logic [NPH-1:0]      brready,
  output logic                rden,
  output logic [BRCW-1:0]     rdaddr,
  input  logic [BRDW-1:0]     rddat,
  output logic                brvld,
  output logic [BRCW-1:0]     bridx,
  output logic [BRDW-1:0]     brdat,
  output logic [PHW-1:0]      brphase,
  output logic                busy,
  output logic                brdone,
  output logic                brerr
);

  import rrc_pkg::*;

  localparam logic [BRCW-1:0] c_LAST    = BRCW'(BRC - 1);
  localparam logic [PHW-1:0]  c_PH_LAST = PHW'(NPH - 1);

  brdist_state_e   r_state;
  brdist_state_e   w_nxt;
  logic [BRCW-1:0] r_bridx;
  logic [PHW-1:0]  r_brphase;
  logic [BRDW-1:0] r_brdat;
  logic [GAPW-1:0] r_gap;

  logic [BRCW-1:0] w_phend;
  logic            w_rdy;
  logic            w_is_last;

  // Select the current phase's end index and ready bit. Walking the
  // phases keeps the lookup in range even when NPH is not a power of two.
  always_comb begin
    w_phend = '0;
    w_rdy   = 1'b0;
    for (int k = 0; k < NPH; k++) begin
      if (r_brphase == PHW'(k)) begin
        w_phend = phend[k*BRCW +: BRCW];
        w_rdy   = brready[k];
      end
    end
  end

  assign w_is_last = (r_bridx == c_LAST);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clksys) begin
    if (sysreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE,
      ST_DONE: begin
        if (start) begin
          w_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_rdy) begin
          w_nxt = ST_FETCH;
        end
      end
      ST_FETCH: w_nxt = ST_LOAD;
      ST_LOAD:  w_nxt = ST_SEND;
      ST_SEND: begin
        if (w_is_last) begin
          w_nxt = ST_DONE;
        end else if (gapcyc != '0) begin
          w_nxt = ST_GAP;
        end else begin
          w_nxt = ST_WAIT;
        end
      end
      ST_GAP: begin
        // r_gap holds the remaining gap cycles including this one.
        if (r_gap <= GAPW'(1)) begin
          w_nxt = ST_WAIT;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    rden   = 1'b0;
    brvld  = 1'b0;
    busy   = 1'b1;
    brdone = 1'b0;
    case (r_state)
      ST_IDLE:  busy = 1'b0;
      ST_DONE: begin
        busy   = 1'b0;
        brdone = 1'b1;
      end
      ST_FETCH: rden  = 1'b1;
      ST_SEND:  brvld = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clksys) begin
    if (sysreset) begin
      r_bridx   <= '0;
      r_brphase <= '0;
      r_brdat   <= '0;
      r_gap     <= '0;
    end else begin
      case (r_state)
        ST_IDLE,
        ST_DONE: begin
          if (start) begin
            r_bridx   <= '0;
            r_brphase <= '0;
          end
        end
        ST_LOAD: r_brdat <= rddat;
        ST_SEND: begin
          // The last record leaves index and phase parked for inspection.
          if (!w_is_last) begin
            r_bridx <= r_bridx + BRCW'(1);
            if ((r_bridx == w_phend) && (r_brphase < c_PH_LAST)) begin
              r_brphase <= r_brphase + PHW'(1);
            end
            r_gap <= gapcyc;
          end
        end
        ST_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - GAPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rdaddr  = r_bridx;
  assign bridx   = r_bridx;
  assign brphase = r_brphase;
  assign brdat   = r_brdat;

  // ------------------------------------------------------------- checksum
`ifdef BRDIST_CHK_EN
  logic w_start_ok;
  logic w_acc;
  logic w_last_send;

  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_acc       = (r_state == ST_SEND) && !w_is_last;
  assign w_last_send = (r_state == ST_SEND) && w_is_last;

  rrc_brdist_chk #(
    .BRDW (BRDW)
  ) u_chk (
    .clk    (clksys),
    .rst    (sysreset),
    .i_clr  (w_start_ok),
    .i_acc  (w_acc),
    .i_last (w_last_send),
    .i_dat  (r_brdat),
    .o_err  (brerr)
  );
`else
  assign brerr = 1'b0;
`endif

endmodule
`default_nettype wire
